// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR sequencer and its datapath.
package fir_pkg;

    localparam int unsigned FIR_LENGTH     = 64;
    localparam int unsigned FIR_IN_WIDTH   = 16;
    localparam int unsigned FIR_OUT_WIDTH  = 38;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MAC     = 2'd1,
        CAPTURE = 2'd2
    } fir_state_e;

    // Tap counter width; never narrower than one bit.
    function automatic int unsigned fir_cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fir_sequencer_if.sv
// Sample, datapath-control and result signals of the FIR sequencer.
interface fir_sequencer_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 38
);
    logic              sample_valid;
    logic              sample_ready;
    logic              Load_FIR_input;
    logic              shift_enable;
    logic [IN_W-1:0]   Filter_coefficeint_select;
    logic              reset_FIR_output;
    logic [OUT_W-1:0]  FIR_output;
    logic [OUT_W-1:0]  result_data;
    logic              result_valid;
    logic              result_ready;

    modport master (
        input  sample_valid, FIR_output, result_ready,
        output sample_ready, Load_FIR_input, shift_enable,
               Filter_coefficeint_select, reset_FIR_output,
               result_data, result_valid
    );

    modport slave (
        output sample_valid, FIR_output, result_ready,
        input  sample_ready, Load_FIR_input, shift_enable,
               Filter_coefficeint_select, reset_FIR_output,
               result_data, result_valid
    );
endinterface

// File: rtl/fir_result_buffer.sv
// Single-entry result hold register with valid/ready; a new capture wins over a drain.
module fir_result_buffer #(
    parameter int unsigned WIDTH = 38
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_set,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_set) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/fir_sequencer.sv
// Sequences FIR_DataPath through one load/shift and LENGTH MAC cycles per sample
// and holds the finished sum for a downstream valid/ready consumer.
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned LENGTH               = FIR_LENGTH,
    parameter int unsigned WIDTH_OF_INPUT_DATA  = FIR_IN_WIDTH,
    parameter int unsigned WIDTH_OF_OUTPUT_DATA = FIR_OUT_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    fir_sequencer_if.master bus
);
    localparam int unsigned     K_W    = fir_cnt_width(LENGTH);
    localparam logic [K_W-1:0]  K_LAST = K_W'(LENGTH - 1);

    fir_state_e                        r_state;
    fir_state_e                        w_state_nxt;
    logic [K_W-1:0]                    r_k;
    logic [K_W-1:0]                    w_k_nxt;
    logic                              w_sample_ready;
    logic                              w_accept;
    logic                              w_capture;
    logic                              w_clr_acc;
    logic [WIDTH_OF_INPUT_DATA-1:0]    w_sel;
    logic                              w_result_valid;
    logic [WIDTH_OF_OUTPUT_DATA-1:0]   w_result_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Next state and datapath controls; reset forces the idle/clear pattern.
    always_comb begin
        w_state_nxt    = r_state;
        w_k_nxt        = r_k;
        w_sample_ready = 1'b0;
        w_accept       = 1'b0;
        w_capture      = 1'b0;
        w_clr_acc      = 1'b1;
        w_sel          = '0;

        case (r_state)
            IDLE: begin
                w_sample_ready = !w_result_valid || bus.result_ready;
                if (bus.sample_valid && w_sample_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = MAC;
                    w_k_nxt     = '0;
                end
            end
            MAC: begin
                w_clr_acc = 1'b0;
                w_sel     = WIDTH_OF_INPUT_DATA'(r_k);
                w_k_nxt   = K_W'(r_k + 1'b1);
                if (r_k == K_LAST) begin
                    w_state_nxt = CAPTURE;
                    w_k_nxt     = '0;
                end
            end
            CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_k_nxt     = '0;
            end
        endcase

        if (reset) begin
            w_sample_ready = 1'b0;
            w_accept       = 1'b0;
            w_capture      = 1'b0;
            w_clr_acc      = 1'b1;
            w_sel          = '0;
        end
    end

    fir_result_buffer #(
        .WIDTH (WIDTH_OF_OUTPUT_DATA)
    ) u_result_buffer (
        .clk     (clk),
        .reset   (reset),
        .i_set   (w_capture),
        .i_data  (bus.FIR_output),
        .i_ready (bus.result_ready),
        .o_valid (w_result_valid),
        .o_data  (w_result_data)
    );

    assign bus.sample_ready              = w_sample_ready;
    assign bus.Load_FIR_input            = w_accept;
    assign bus.shift_enable              = w_accept;
    assign bus.Filter_coefficeint_select = w_sel;
    assign bus.reset_FIR_output          = w_clr_acc;
    assign bus.result_valid              = w_result_valid;
    assign bus.result_data               = w_result_data;
endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer with a 4-tap behavioural datapath, coefficients {1,2,3,4}.
module tb_fir_sequencer;
    import fir_pkg::*;

    localparam int unsigned L  = 4;
    localparam int unsigned IW = 16;
    localparam int unsigned OW = 38;

    logic          clk = 1'b0;
    logic          reset;
    logic [IW-1:0] sample_data;
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    fir_sequencer_if #(.IN_W(IW), .OUT_W(OW)) bus ();

    fir_sequencer #(
        .LENGTH               (L),
        .WIDTH_OF_INPUT_DATA  (IW),
        .WIDTH_OF_OUTPUT_DATA (OW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural FIR_DataPath: taps[0] is the newest sample, coef[k] = k+1.
    logic [IW-1:0] taps [L];
    logic [OW-1:0] acc;
    logic [OW-1:0] prod;

    always_comb begin
        prod = '0;
        if (bus.Filter_coefficeint_select < IW'(L))
            prod = OW'(taps[int'(bus.Filter_coefficeint_select)]) *
                   OW'(int'(bus.Filter_coefficeint_select) + 1);
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < L; i++) taps[i] <= '0;
        end else begin
            if (bus.shift_enable)
                for (int i = 1; i < L; i++) taps[i] <= taps[i-1];
            if (bus.Load_FIR_input) taps[0] <= sample_data;
        end
        if (bus.reset_FIR_output) acc <= '0;
        else                      acc <= acc + prod;
    end

    assign bus.FIR_output = acc;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.sample_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Accept a sample at the current negedge and return just after the accepting edge.
    task automatic send_sample(input logic [IW-1:0] d, output bit accepted);
        tick();
        sample_data = d;
        bus.sample_valid = 1'b1;
        #1;
        accepted = bus.sample_ready;
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            #1;
            if (bus.result_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.sample_valid = 1'b0;
        bus.result_ready = 1'b0;
        sample_data = '0;
        tick(); tick(); #1;
        checks++; if (bus.Load_FIR_input !== 1'b0) begin failures++; $display("FAIL reset_load: got %b want 0", bus.Load_FIR_input); end
        checks++; if (bus.shift_enable !== 1'b0) begin failures++; $display("FAIL reset_shift: got %b want 0", bus.shift_enable); end
        checks++; if (bus.reset_FIR_output !== 1'b1) begin failures++; $display("FAIL reset_clr: got %b want 1", bus.reset_FIR_output); end
        checks++; if (bus.Filter_coefficeint_select !== '0) begin failures++; $display("FAIL reset_sel: got %0d want 0", bus.Filter_coefficeint_select); end
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.result_valid); end
        checks++; if (bus.result_data !== '0) begin failures++; $display("FAIL reset_data: got %0d want 0", bus.result_data); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        bit got = 1'b0;
        int lat = -1;
        int loads = 0;
        apply_reset();
        bus.result_ready = 1'b1;
        tick();
        sample_data = 16'd5;
        bus.sample_valid = 1'b1;
        #1;
        checks++;
        if ({bus.sample_ready, bus.Load_FIR_input, bus.shift_enable} !== 3'b111) begin
            failures++; $display("FAIL single_accept: got %b want 111", {bus.sample_ready, bus.Load_FIR_input, bus.shift_enable});
        end
        for (int i = 1; i <= 20 && !got; i++) begin
            tick();
            bus.sample_valid = 1'b0;
            #1;
            if (i <= 4) begin
                checks++;
                if (bus.Filter_coefficeint_select !== IW'(i - 1) || bus.reset_FIR_output !== 1'b0) begin
                    failures++; $display("FAIL single_sel%0d: got sel=%0d clr=%b want sel=%0d clr=0", i, bus.Filter_coefficeint_select, bus.reset_FIR_output, i - 1);
                end
            end
            if (bus.Load_FIR_input) loads++;
            if (bus.result_valid) begin got = 1'b1; lat = i; end
        end
        checks++; if (lat != 6) begin failures++; $display("FAIL single_latency: got %0d want 6", lat); end
        checks++; if (bus.result_data !== OW'(5)) begin failures++; $display("FAIL single_data: got %0d want 5", bus.result_data); end
        checks++; if (loads != 0) begin failures++; $display("FAIL single_extra_loads: got %0d want 0", loads); end
        tick(); #1;
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL single_drain: got %b want 0", bus.result_valid); end
    endtask

    task automatic test_back_to_back();
        int acc_n = 0;
        int res_n = 0;
        int acc_cyc [2] = '{-100, -100};
        int res_cyc [2] = '{-100, -100};
        logic [OW-1:0] res [2] = '{'0, '0};
        apply_reset();
        bus.result_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            bus.sample_valid = (acc_n < 2);
            sample_data = (acc_n == 0) ? 16'd5 : 16'd7;
            #1;
            if (bus.result_valid && res_n < 2) begin
                res[res_n] = bus.result_data; res_cyc[res_n] = i; res_n++;
            end
            if (bus.sample_valid && bus.sample_ready && acc_n < 2) begin
                acc_cyc[acc_n] = i; acc_n++;
            end
        end
        bus.sample_valid = 1'b0;
        checks++; if (acc_cyc[1] - acc_cyc[0] != 6) begin failures++; $display("FAIL b2b_spacing: got %0d want 6", acc_cyc[1] - acc_cyc[0]); end
        checks++; if (res_cyc[0] - acc_cyc[0] != 6) begin failures++; $display("FAIL b2b_latency: got %0d want 6", res_cyc[0] - acc_cyc[0]); end
        checks++; if (res_n != 2) begin failures++; $display("FAIL b2b_count: got %0d want 2", res_n); end
        checks++; if (res[0] !== OW'(5)) begin failures++; $display("FAIL b2b_res0: got %0d want 5", res[0]); end
        checks++; if (res[1] !== OW'(17)) begin failures++; $display("FAIL b2b_res1: got %0d want 17", res[1]); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        apply_reset();
        bus.result_ready = 1'b0;
        tick();
        sample_data = 16'd5;
        bus.sample_valid = 1'b1;
        #1;
        checks++; if (bus.sample_ready !== 1'b1) begin failures++; $display("FAIL bp_first_accept: got %b want 1", bus.sample_ready); end
        @(posedge clk); #1;
        sample_data = 16'd7;
        wait_valid(n);
        checks++; if (n != 6) begin failures++; $display("FAIL bp_latency: got %0d want 6", n); end
        for (int j = 0; j < 3; j++) begin
            tick(); #1;
            checks++;
            if (bus.sample_ready !== 1'b0 || bus.Load_FIR_input !== 1'b0 || bus.result_data !== OW'(5)) begin
                failures++; $display("FAIL bp_hold%0d: got ready=%b load=%b data=%0d want 0 0 5", j, bus.sample_ready, bus.Load_FIR_input, bus.result_data);
            end
        end
        tick();
        bus.result_ready = 1'b1;
        #1;
        checks++;
        if ({bus.sample_ready, bus.Load_FIR_input, bus.shift_enable} !== 3'b111) begin
            failures++; $display("FAIL bp_release_accept: got %b want 111", {bus.sample_ready, bus.Load_FIR_input, bus.shift_enable});
        end
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        checks++; if (bus.result_valid !== 1'b0) begin failures++; $display("FAIL bp_drained: got %b want 0", bus.result_valid); end
        wait_valid(n);
        checks++; if (n != 6 || bus.result_data !== OW'(17)) begin failures++; $display("FAIL bp_second: got lat=%0d data=%0d want 6 17", n, bus.result_data); end
        ok = 1'b1;
    endtask

    task automatic test_reset_mid_mac();
        bit acc_ok;
        int n;
        int spurious = 0;
        apply_reset();
        bus.result_ready = 1'b1;
        send_sample(16'd5, acc_ok);
        tick(); tick(); tick(); #1;
        checks++; if (bus.Filter_coefficeint_select !== IW'(2)) begin failures++; $display("FAIL rst_mac_sel: got %0d want 2", bus.Filter_coefficeint_select); end
        reset = 1'b1;
        #1;
        checks++; if (bus.reset_FIR_output !== 1'b1 || bus.Filter_coefficeint_select !== '0) begin failures++; $display("FAIL rst_mac_force: got clr=%b sel=%0d want 1 0", bus.reset_FIR_output, bus.Filter_coefficeint_select); end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.result_valid, bus.reset_FIR_output, bus.sample_ready} !== 3'b011) begin
            failures++; $display("FAIL rst_mac_idle: got valid/clr/ready=%b want 011", {bus.result_valid, bus.reset_FIR_output, bus.sample_ready});
        end
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            if (bus.result_valid) spurious++;
        end
        checks++; if (spurious != 0) begin failures++; $display("FAIL rst_mac_no_result: got %0d want 0", spurious); end
        send_sample(16'd3, acc_ok);
        checks++; if (!acc_ok) begin failures++; $display("FAIL rst_mac_accept: got 0 want 1"); end
        wait_valid(n);
        checks++; if (n != 6 || bus.result_data !== OW'(3)) begin failures++; $display("FAIL rst_mac_result: got lat=%0d data=%0d want 6 3", n, bus.result_data); end
    endtask

    task automatic test_idle();
        int n;
        tick();
        bus.result_ready = 1'b0;
        sample_data = 16'd2;
        bus.sample_valid = 1'b1;
        #1;
        checks++; if (bus.sample_ready !== 1'b1) begin failures++; $display("FAIL idle_accept: got %b want 1", bus.sample_ready); end
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        wait_valid(n);
        checks++; if (n != 6 || bus.result_data !== OW'(8)) begin failures++; $display("FAIL idle_result: got lat=%0d data=%0d want 6 8", n, bus.result_data); end
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            checks++;
            if ({bus.Load_FIR_input, bus.shift_enable, bus.reset_FIR_output, bus.result_valid} !== 4'b0011 || bus.result_data !== OW'(8)) begin
                failures++; $display("FAIL idle_cycle%0d: got ld/sh/clr/v=%b data=%0d want 0011 8", i,
                    {bus.Load_FIR_input, bus.shift_enable, bus.reset_FIR_output, bus.result_valid}, bus.result_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_mac();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
